allpass_diffuser: RTL and testbench

- Schroeder allpass diffusion stage directly downstream of the comb filter bank in the reverb path.
- Takes the comb (or summed comb) output as a strobed 32-bit signed sample stream.
- Applies one allpass section with gain g = 0.5 and a DEPTH-sample delay line, then emits a strobed, saturated 32-bit result.
- Owns a zero-fill sweep of its delay memory, so no stale or unknown contents ever reach the output.

---
 rtl/allpass_diffuser.sv | 154 +++++++++++++++
 tb/tb_allpass_diffuser.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/allpass_diffuser.sv
// rtl/allpass_diffuser.sv - Schroeder allpass diffusion stage (g = 0.5, DEPTH-sample delay line)
// Three-stage pipeline over a read-first block RAM, with a zero-fill sweep owned by the FSM.
module allpass_diffuser #(
  parameter int DEPTH = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               in_valid,
  input  logic signed [31:0] in,
  output logic               out_valid,
  output logic signed [31:0] out,
  output logic               busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_RUN,
    ST_BYPASS
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      clear_cnt;
  logic [PW-1:0]      s1_ptr;
  logic               s1_valid;
  logic               s1_wet;
  logic signed [31:0] s1_x;
  logic signed [31:0] rd_data;
  logic               s2_valid;
  logic signed [31:0] s2_y;
  logic signed [33:0] v_sum;
  logic signed [33:0] y_sum;
  logic signed [31:0] v;
  logic signed [31:0] y;
  logic               accept_wet;

  logic signed [31:0] mem [DEPTH];

  function automatic logic signed [31:0] sat32(input logic signed [33:0] s);
    if (s[33:31] == 3'b000 || s[33:31] == 3'b111) begin
      return s[31:0];
    end else if (s[33]) begin
      return 32'sh8000_0000;
    end else begin
      return 32'sh7FFF_FFFF;
    end
  endfunction

  // Reset lands directly in the mode selected by enable so busy is valid during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= enable ? ST_CLEAR : ST_BYPASS;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy = 1'b1;
        if (!enable) begin
          state_nxt = ST_BYPASS;
        end else if (clear_cnt == LAST) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_nxt = ST_BYPASS;
        end
      end
      ST_BYPASS: begin
        if (enable) begin
          state_nxt = ST_CLEAR;
        end
      end
      default: begin
        state_nxt = ST_BYPASS;
      end
    endcase
  end

  assign accept_wet = in_valid && (state == ST_RUN);

  always_comb begin
    v_sum = {{2{s1_x[31]}}, s1_x} + {{3{rd_data[31]}}, rd_data[31:1]};
    v     = sat32(v_sum);
    y_sum = {{2{rd_data[31]}}, rd_data} - {{3{v[31]}}, v[31:1]};
    y     = sat32(y_sum);
  end

  // Read-first port: the tap for a new sample is fetched before any same-edge write lands.
  // The clear sweep and a wet write-back can never share an edge: CLEAR is only entered from BYPASS.
  always_ff @(posedge clk) begin
    if (accept_wet) begin
      rd_data <= mem[ptr];
    end
    if (state == ST_CLEAR) begin
      mem[clear_cnt] <= '0;
    end else if (s1_valid && s1_wet) begin
      mem[s1_ptr] <= v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_wet    <= 1'b0;
      s1_x      <= '0;
      s1_ptr    <= '0;
      s2_valid  <= 1'b0;
      s2_y      <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      ptr       <= '0;
      clear_cnt <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x   <= in;
        s1_wet <= (state == ST_RUN);
        s1_ptr <= ptr;
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y <= s1_wet ? y : s1_x;
      end

      out_valid <= s2_valid;
      if (s2_valid) begin
        out <= s2_y;
      end

      // Pointer moves at acceptance so back-to-back samples read the next tap.
      if (state != ST_RUN) begin
        ptr <= '0;
      end else if (in_valid) begin
        ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
      end

      clear_cnt <= (state == ST_CLEAR) ? clear_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_allpass_diffuser.sv
// tb/tb_allpass_diffuser.sv - table-driven scoreboard bench for allpass_diffuser, DEPTH = 4
module tb_allpass_diffuser;

  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               enable = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [31:0] din = '0;
  logic               out_valid;
  logic signed [31:0] dout;
  logic               busy;

  allpass_diffuser #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .in_valid (in_valid),
    .in       (din),
    .out_valid(out_valid),
    .out      (dout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] din;
    logic signed [31:0] dout;
  } vec_t;

  typedef struct {
    int val;
    int due;
  } exp_t;

  vec_t tbl[20];
  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("out_value", dout, mon_e.val);
        check("out_latency_edge", cyc, mon_e.due);
      end
    end
  end

  // Called just after an edge; the sample is accepted at the next edge and due two edges later.
  task automatic drive(input logic signed [31:0] x, input logic signed [31:0] e);
    in_valid = 1'b1;
    din      = x;
    sb.push_back('{int'(e), cyc + 3});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #1;
    check("drain_outstanding", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_vecs(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      drive(tbl[i].din, tbl[i].dout);
      step();
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic wait_clear(string nm);
    int n = 0;
    for (int i = 0; i < 20 && !busy; i++) step();
    check({nm, "_busy_rise"}, int'(busy), 1);
    while (busy && n < 50) begin
      step();
      n++;
    end
    check({nm, "_busy_cycles"}, n, DEPTH);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 12; i++) tbl[i] = '{32'sd0, 32'sd0};
    tbl[0]  = '{32'sd1000, -32'sd500};
    tbl[4]  = '{32'sd0, 32'sd750};
    tbl[8]  = '{32'sd0, 32'sd375};
    for (int i = 12; i < 16; i++) tbl[i] = '{32'sh7FFF_FFFF, -32'sd1073741823};
    tbl[16] = '{32'sh7FFF_FFFF, 32'sd1073741824};
    tbl[17] = '{-32'sd12345, -32'sd12345};
    tbl[18] = '{32'sh7FFF_FFFF, 32'sh7FFF_FFFF};
    tbl[19] = '{32'sh8000_0000, 32'sh8000_0000};

    // Reset with enable high
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 1);
    check("reset_out", dout, 0);
    check("reset_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    wait_clear("post_reset");
    check("post_reset_out", dout, 0);

    run_vecs(0, 12);

    // Dry bypass
    enable = 1'b0;
    step();
    check("bypass_busy", int'(busy), 0);
    run_vecs(17, 3);

    // Re-enable: fresh clear, identical impulse response
    enable = 1'b1;
    wait_clear("reenable");
    run_vecs(0, 12);

    // Saturation on a freshly cleared line
    enable = 1'b0;
    step();
    enable = 1'b1;
    wait_clear("pre_sat");
    run_vecs(12, 5);

    // Abort a clear after two cycles; a sample arriving mid-clear passes dry
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    check("abort_busy_start", int'(busy), 1);
    drive(32'sd31337, 32'sd31337);
    step();
    in_valid = 1'b0;
    step();
    check("abort_busy_two_cycles", int'(busy), 1);
    enable = 1'b0;
    step();
    check("abort_busy_fall", int'(busy), 0);
    drive(32'sd777, 32'sd777);
    step();
    in_valid = 1'b0;
    drain();
    enable = 1'b1;
    wait_clear("after_abort");
    run_vecs(0, 12);

    // Reset with two samples in flight
    enable = 1'b0;
    step();
    drive(32'sd4242, 32'sd4242);
    step();
    in_valid = 1'b0;
    drain();
    check("pre_reset_out", dout, 4242);
    in_valid = 1'b1;
    din = 32'sd11;
    step();
    din = 32'sd22;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", dout, 0);
    check("async_reset_out_valid", int'(out_valid), 0);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("inflight_killed_in_reset", int'(out_valid), 0);
    end
    rst_n = 1'b1;
    #1;
    check("release_ptr", int'(dut.ptr), 0);
    check("release_busy_bypass", int'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("inflight_killed_after_release", int'(out_valid), 0);
    end
    enable = 1'b1;
    wait_clear("final");
    run_vecs(0, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
